// File: rtl/ddr_rd_uart_tx.sv
// ddr_rd_uart_tx
//   Return path of the DDR UART test design. Accepts one DATA_W-bit word read
//   from DDR and sends it as NUM_BYTES back-to-back UART 8N1 frames,
//   least-significant byte first and LSB first within each byte.
//
// Ports
//   i_clk        single clock, rising edge
//   rst          synchronous active-high reset
//   i_valid      read word available
//   o_ready      high only while idle; a word is taken when i_valid && o_ready
//   i_data       read word, captured only on the handshake edge
//   o_tx         UART serial line, idles high
//   o_busy       high from the handshake until the last stop bit completes
//   o_tx_byte    byte currently being serialised (debug)
//   o_byte_done  one-cycle pulse after each stop bit
//   o_word_done  one-cycle pulse after the last byte's stop bit
module ddr_rd_uart_tx #(
    parameter int DATA_W       = 256,
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_BYTES    = DATA_W / 8
) (
    input  logic              i_clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_tx,
    output logic              o_busy,
    output logic [7:0]        o_tx_byte,
    output logic              o_byte_done,
    output logic              o_word_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BYTE_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [BYTE_W-1:0]   byte_q, byte_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [DATA_W-1:0]   shreg_next;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic [7:0]          cur_byte;
    logic                tx_q, tx_d;
    logic                byte_done_q, byte_done_d;
    logic                word_done_q, word_done_d;
    logic                baud_end;

    assign baud_end   = (baud_q == BAUD_LAST);
    assign shreg_next = shreg_q >> 8;

    // Next-state and datapath logic
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        shreg_d     = shreg_q;
        tx_byte_d   = tx_byte_q;
        byte_done_d = 1'b0;
        word_done_d = 1'b0;
        cur_byte    = 8'h00;
        tx_d        = 1'b1;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                byte_d = '0;
                if (i_valid) begin
                    state_d   = START;
                    shreg_d   = i_data;
                    tx_byte_d = i_data[7:0];
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d      = '0;
                    bit_d       = '0;
                    byte_done_d = 1'b1;
                    if (byte_q == BYTE_LAST) begin
                        word_done_d = 1'b1;
                        byte_d      = '0;
                        state_d     = IDLE;
                    end else begin
                        // Next byte follows the stop bit with no idle gap.
                        byte_d    = byte_q + BYTE_W'(1);
                        shreg_d   = shreg_next;
                        tx_byte_d = shreg_next[7:0];
                        state_d   = START;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is registered from the next state so o_tx changes
        // on the same edge as the state and never glitches.
        cur_byte = shreg_d[7:0];
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    // Control registers
    always_ff @(posedge i_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            tx_q        <= 1'b1;
            tx_byte_q   <= 8'h00;
            byte_done_q <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            tx_q        <= tx_d;
            tx_byte_q   <= tx_byte_d;
            byte_done_q <= byte_done_d;
            word_done_q <= word_done_d;
        end
    end

    // Word shift register; only meaningful while a word is in flight
    always_ff @(posedge i_clk) begin
        shreg_q <= shreg_d;
    end

    assign o_ready     = (state_q == IDLE);
    assign o_busy      = (state_q != IDLE);
    assign o_tx        = tx_q;
    assign o_tx_byte   = tx_byte_q;
    assign o_byte_done = byte_done_q;
    assign o_word_done = word_done_q;

endmodule

// File: tb/tb_ddr_rd_uart_tx.sv
// Testbench for ddr_rd_uart_tx with CLKS_PER_BIT=4. Every transmitted word is
// compared cycle by cycle with the ideal 8N1 waveform derived from the word.
module tb_ddr_rd_uart_tx;

    localparam int DW    = 256;
    localparam int C     = 4;
    localparam int NB    = DW / 8;
    localparam int FRAME = 10 * C;
    localparam int NCYC  = NB * FRAME;

    logic          clk;
    logic          rst;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic          o_tx;
    logic          o_busy;
    logic [7:0]    o_tx_byte;
    logic          o_byte_done;
    logic          o_word_done;

    int n_checks = 0;
    int n_fail   = 0;

    ddr_rd_uart_tx #(.DATA_W(DW), .CLKS_PER_BIT(C)) dut (
        .i_clk       (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data      (i_data),
        .o_tx        (o_tx),
        .o_busy      (o_busy),
        .o_tx_byte   (o_tx_byte),
        .o_byte_done (o_byte_done),
        .o_word_done (o_word_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int j = 0; j < DW / 32; j++) w[32*j +: 32] = $urandom();
        return w;
    endfunction

    // Present a word and wait (bounded) for the handshake edge; returns at the
    // falling edge of the first start-bit cycle.
    task automatic handshake(input logic [DW-1:0] w);
        bit ok;
        ok = 0;
        i_valid = 1'b1;
        i_data  = w;
        for (int t = 0; t < 50; t++) begin
            if (o_ready === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("hs_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Observe one whole word from its first start-bit cycle (k=0) to the
    // word_done cycle (k=NCYC). Expected line level for cycle k: bit slot
    // pos=(k%FRAME)/C of byte k/FRAME, slot 0 = start(0), 9 = stop(1).
    task automatic transmit(input logic [DW-1:0] w, input bit scramble,
                            input bit keep_valid, input logic [DW-1:0] nw,
                            output logic [9:0] first_frame);
        int wave_err, byte_err, bd_err, rdy_err, busy_err, wd_err;
        int byte_i, pos;
        logic exp_bit;
        wave_err = 0; byte_err = 0; bd_err = 0; rdy_err = 0; busy_err = 0; wd_err = 0;
        first_frame = '0;
        for (int k = 0; k <= NCYC; k++) begin
            if (k > 0) @(negedge clk);
            if (k < NCYC) begin
                byte_i  = k / FRAME;
                pos     = (k % FRAME) / C;
                exp_bit = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : w[8*byte_i + pos - 1];
                if (o_tx !== exp_bit) wave_err++;
                if (k < FRAME && (k % C) == C / 2) first_frame[pos] = o_tx;
                if (o_tx_byte !== w[8*byte_i +: 8]) byte_err++;
                if (o_byte_done !== (k > 0 && (k % FRAME) == 0)) bd_err++;
                if (o_ready !== 1'b0) rdy_err++;
                if (o_busy !== 1'b1) busy_err++;
                if (o_word_done !== 1'b0) wd_err++;
                if (scramble) i_data = rand_word();
                if (!keep_valid) i_valid = 1'b0;
            end else begin
                check("word_done_at_end", o_word_done, 1);
                check("byte_done_at_end", o_byte_done, 1);
                check("ready_at_end", o_ready, 1);
                check("busy_at_end", o_busy, 0);
                check("tx_idle_at_end", o_tx, 1);
                if (keep_valid) i_data = nw;
                else i_valid = 1'b0;
            end
        end
        check("wave_errors", wave_err, 0);
        check("tx_byte_errors", byte_err, 0);
        check("byte_done_errors", bd_err, 0);
        check("ready_low_errors", rdy_err, 0);
        check("busy_high_errors", busy_err, 0);
        check("word_done_early", wd_err, 0);
    endtask

    initial begin
        logic [DW-1:0] w, w2;
        logic [9:0]    ff;
        int            bad;

        rst     = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", o_tx, 1);
        check("rst_ready", o_ready, 1);
        check("rst_busy", o_busy, 0);
        check("rst_tx_byte", o_tx_byte, 0);
        check("rst_byte_done", o_byte_done, 0);
        check("rst_word_done", o_word_done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Incrementing bytes 0x00..0x1F
        for (int i = 0; i < NB; i++) w[8*i +: 8] = 8'(i);
        handshake(w);
        transmit(w, 0, 0, '0, ff);
        repeat (3) @(negedge clk);

        // Single byte 0xA5, rest zero
        w = '0;
        w[7:0] = 8'hA5;
        handshake(w);
        transmit(w, 0, 0, '0, ff);
        check("frame_a5", ff, 10'b1101001010);
        repeat (2) @(negedge clk);

        // Random words with i_data changing every cycle after the handshake
        for (int r = 0; r < 2; r++) begin
            w = rand_word();
            handshake(w);
            transmit(w, 1, 0, '0, ff);
            @(negedge clk);
        end

        // Back-to-back words with i_valid held high
        w  = rand_word();
        w2 = rand_word();
        handshake(w);
        transmit(w, 0, 1, w2, ff);
        @(posedge clk);
        @(negedge clk);
        check("b2b_second_start", o_tx, 0);
        transmit(w2, 0, 0, '0, ff);
        @(negedge clk);

        // All-zeros and all-ones words
        w = '0;
        handshake(w);
        transmit(w, 0, 0, '0, ff);
        @(negedge clk);
        w = '1;
        handshake(w);
        transmit(w, 0, 0, '0, ff);
        @(negedge clk);

        // Reset during byte 5, data bit 3
        w = rand_word();
        handshake(w);
        i_valid = 1'b0;
        for (int k = 1; k <= 5 * FRAME + 4 * C + 1; k++) @(negedge clk);
        check("pre_rst_busy", o_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx", o_tx, 1);
        check("midrst_ready", o_ready, 1);
        check("midrst_busy", o_busy, 0);
        check("midrst_tx_byte", o_tx_byte, 0);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            @(negedge clk);
            if (o_word_done !== 1'b0 || o_byte_done !== 1'b0 || o_tx !== 1'b1 || o_busy !== 1'b0) bad++;
        end
        check("after_midrst_quiet", bad, 0);
        w = '1;
        handshake(w);
        transmit(w, 0, 0, '0, ff);
        @(negedge clk);

        // Reset together with a handshake
        rst     = 1'b1;
        i_valid = 1'b1;
        i_data  = rand_word();
        @(negedge clk);
        rst     = 1'b0;
        i_valid = 1'b0;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_ready !== 1'b1) bad++;
            @(negedge clk);
        end
        check("collision_no_tx", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
